// File: rtl/sine_wave_analyzer.sv
// Measures period, peak, trough and amplitude of a sampled sine wave using
// rising midscale crossings with hysteresis. One result per full cycle.
module sine_wave_analyzer #(
    parameter int DATA_WIDTH   = 10,
    parameter int MIDSCALE     = 512,
    parameter int HYST         = 16,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic [DATA_WIDTH-1:0]   data_sin,
    output logic                    result_valid,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic [DATA_WIDTH-1:0]   peak_max,
    output logic [DATA_WIDTH-1:0]   peak_min,
    output logic [DATA_WIDTH-1:0]   amplitude,
    output logic                    locked,
    output logic                    timeout
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ARM1    = 2'd1,
        MEAS_HI = 2'd2,
        MEAS_LO = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0]   LO_TH   = DATA_WIDTH'(MIDSCALE - HYST);
    localparam logic [DATA_WIDTH-1:0]   HI_TH   = DATA_WIDTH'(MIDSCALE + HYST);
    localparam logic [PERIOD_WIDTH-1:0] CNT_ONE = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = {PERIOD_WIDTH{1'b1}};

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0]   run_max_q, run_max_d;
    logic [DATA_WIDTH-1:0]   run_min_q, run_min_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [DATA_WIDTH-1:0]   peak_max_q, peak_max_d;
    logic [DATA_WIDTH-1:0]   peak_min_q, peak_min_d;
    logic [DATA_WIDTH-1:0]   amplitude_q, amplitude_d;
    logic                    result_valid_q, result_valid_d;
    logic                    locked_q, locked_d;
    logic                    timeout_q, timeout_d;

    logic                    is_low, is_high;
    logic [PERIOD_WIDTH-1:0] count_inc;
    logic                    count_sat;
    logic [DATA_WIDTH-1:0]   track_max, track_min;

    assign is_low    = sample_valid && (data_sin <= LO_TH);
    assign is_high   = sample_valid && (data_sin >= HI_TH);
    assign count_inc = count_q + CNT_ONE;
    assign count_sat = (count_inc == CNT_MAX);
    assign track_max = (data_sin > run_max_q) ? data_sin : run_max_q;
    assign track_min = (data_sin < run_min_q) ? data_sin : run_min_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d        = state_q;
        count_d        = count_q;
        run_max_d      = run_max_q;
        run_min_d      = run_min_q;
        period_d       = period_q;
        peak_max_d     = peak_max_q;
        peak_min_d     = peak_min_q;
        amplitude_d    = amplitude_q;
        result_valid_d = 1'b0;
        locked_d       = locked_q;
        timeout_d      = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (is_low) begin
                    state_d = ARM1;
                    count_d = '0;
                end
            end
            ARM1: begin
                if (is_high) begin
                    state_d   = MEAS_HI;
                    count_d   = CNT_ONE;
                    run_max_d = data_sin;
                    run_min_d = data_sin;
                end else if (sample_valid) begin
                    count_d = count_inc;
                    if (count_sat) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        state_d   = HUNT;
                    end
                end
            end
            MEAS_HI, MEAS_LO: begin
                if (state_q == MEAS_LO && is_high) begin
                    // Closing crossing: latch the finished cycle, the crossing sample seeds the next one.
                    period_d       = count_q;
                    peak_max_d     = run_max_q;
                    peak_min_d     = run_min_q;
                    amplitude_d    = (run_max_q - run_min_q) >> 1;
                    result_valid_d = 1'b1;
                    locked_d       = 1'b1;
                    count_d        = CNT_ONE;
                    run_max_d      = data_sin;
                    run_min_d      = data_sin;
                    state_d        = MEAS_HI;
                end else if (sample_valid) begin
                    count_d   = count_inc;
                    run_max_d = track_max;
                    run_min_d = track_min;
                    if (count_sat) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        state_d   = HUNT;
                    end else if (state_q == MEAS_HI && is_low) begin
                        state_d = MEAS_LO;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= HUNT;
            count_q        <= '0;
            run_max_q      <= '0;
            run_min_q      <= '0;
            period_q       <= '0;
            peak_max_q     <= '0;
            peak_min_q     <= '0;
            amplitude_q    <= '0;
            result_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            run_max_q      <= run_max_d;
            run_min_q      <= run_min_d;
            period_q       <= period_d;
            peak_max_q     <= peak_max_d;
            peak_min_q     <= peak_min_d;
            amplitude_q    <= amplitude_d;
            result_valid_q <= result_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign result_valid = result_valid_q;
    assign period       = period_q;
    assign peak_max     = peak_max_q;
    assign peak_min     = peak_min_q;
    assign amplitude    = amplitude_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_sine_wave_analyzer.sv
// Directed bench for sine_wave_analyzer: full-scale sine, gapped valid, hysteresis,
// threshold boundaries, minimum period, timeout (8-bit counter copy) and mid-cycle reset.
module tb_sine_wave_analyzer;

    logic        clock;
    logic        reset;
    logic        sample_valid;
    logic [9:0]  data_sin;

    logic        result_valid, locked, timeout;
    logic [15:0] period;
    logic [9:0]  peak_max, peak_min, amplitude;

    logic        result_valid8, locked8, timeout8;
    logic [7:0]  period8;
    logic [9:0]  peak_max8, peak_min8, amplitude8;

    int checks   = 0;
    int failures = 0;
    int n_res    = 0;
    int n_res8   = 0;
    int n_to8    = 0;
    int both_hi  = 0;

    sine_wave_analyzer dut (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .data_sin(data_sin),
        .result_valid(result_valid), .period(period), .peak_max(peak_max),
        .peak_min(peak_min), .amplitude(amplitude), .locked(locked), .timeout(timeout)
    );

    sine_wave_analyzer #(.PERIOD_WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .data_sin(data_sin),
        .result_valid(result_valid8), .period(period8), .peak_max(peak_max8),
        .peak_min(peak_min8), .amplitude(amplitude8), .locked(locked8), .timeout(timeout8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] sine_at(input int i);
        real ph;
        int  v;
        ph = 2.0 * 3.14159265358979 * real'(i % 1024) / 1024.0;
        v  = int'(511.5 + 511.5 * $sin(ph));
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return 10'(v);
    endfunction

    // Present one cycle of input, then observe outputs 1 time unit after the edge.
    task automatic send(input logic [9:0] d, input logic v);
        sample_valid = v;
        data_sin     = d;
        @(posedge clock);
        #1;
        if (result_valid)  n_res++;
        if (result_valid8) n_res8++;
        if (timeout8)      n_to8++;
        if ((result_valid && timeout) || (result_valid8 && timeout8)) both_hi++;
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        data_sin     = '0;
        reset        = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset  = 1'b1;
        n_res  = 0;
        n_res8 = 0;
        n_to8  = 0;
    endtask

    initial begin
        reset        = 1'b0;
        sample_valid = 1'b0;
        data_sin     = '0;
        #12;
        chk("reset_outputs_zero", 32'(|{result_valid, period, peak_max, peak_min, amplitude, timeout}), 0);
        chk("reset_locked", 32'(locked), 0);
        do_reset();

        // Full-scale sine, phase step 1, 5 cycles: crossings at 6, 1030, 2054, 3078, 4102.
        for (int i = 0; i < 2048; i++) send(sine_at(i), 1'b1);
        chk("full_no_result_before_2nd_crossing", n_res, 0);
        for (int i = 2048; i < 2060; i++) send(sine_at(i), 1'b1);
        chk("full_first_result_after_2nd_crossing", n_res, 1);
        for (int i = 2060; i < 5120; i++) send(sine_at(i), 1'b1);
        chk("full_result_count", n_res, 3);
        chk("full_period", 32'(period), 1024);
        chk("full_peak_max", 32'(peak_max), 1023);
        chk("full_peak_min", 32'(peak_min), 0);
        chk("full_amplitude", 32'(amplitude), 511);
        chk("full_locked", 32'(locked), 1);

        // Same stream with an idle (data=0) cycle between every valid sample.
        do_reset();
        for (int i = 0; i < 5120; i++) begin
            send(sine_at(i), 1'b1);
            send(10'd0, 1'b0);
        end
        chk("gap_result_count", n_res, 3);
        chk("gap_period", 32'(period), 1024);
        chk("gap_peak_max", 32'(peak_max), 1023);
        chk("gap_peak_min", 32'(peak_min), 0);
        chk("gap_amplitude", 32'(amplitude), 511);

        // Square wave inside the hysteresis band, then just inside, then exactly at thresholds.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            send(10'd500, 1'b1);
            send(10'd524, 1'b1);
        end
        chk("hyst_no_result", n_res, 0);
        chk("hyst_not_locked", 32'(locked), 0);
        for (int i = 0; i < 4; i++) begin
            send(10'd497, 1'b1);
            send(10'd527, 1'b1);
        end
        chk("hyst_edge_no_result", n_res, 0);
        send(10'd496, 1'b1);
        send(10'd528, 1'b1);
        send(10'd496, 1'b1);
        send(10'd528, 1'b1);
        chk("thresh_result_valid", 32'(result_valid), 1);
        chk("thresh_period", 32'(period), 2);
        chk("thresh_peak_max", 32'(peak_max), 528);
        chk("thresh_peak_min", 32'(peak_min), 496);
        chk("thresh_amplitude", 32'(amplitude), 16);
        send(10'd496, 1'b1);
        chk("thresh_pulse_one_cycle", 32'(result_valid), 0);

        // Minimum period: 400/700 alternating at full rate.
        do_reset();
        send(10'd400, 1'b1);
        send(10'd700, 1'b1);
        chk("minp_no_result_on_arm", n_res, 0);
        for (int k = 1; k <= 4; k++) begin
            send(10'd400, 1'b1);
            chk("minp_low_no_pulse", 32'(result_valid), 0);
            send(10'd700, 1'b1);
            chk("minp_result_count", n_res, k);
        end
        chk("minp_period", 32'(period), 2);
        chk("minp_peak_max", 32'(peak_max), 700);
        chk("minp_peak_min", 32'(peak_min), 400);
        chk("minp_amplitude", 32'(amplitude), 150);

        // Timeout on the 8-bit counter copy: count is 1 after the crossing, saturates at 255.
        do_reset();
        send(10'd300, 1'b1);
        send(10'd700, 1'b1);
        send(10'd300, 1'b1);
        send(10'd700, 1'b1);
        chk("to_locked_before", 32'(locked8), 1);
        chk("to_period_before", 32'(period8), 2);
        for (int i = 0; i < 253; i++) send(10'd700, 1'b1);
        chk("to_no_timeout_at_254", n_to8, 0);
        chk("to_still_locked_at_254", 32'(locked8), 1);
        send(10'd700, 1'b1);
        chk("to_timeout_pulse", 32'(timeout8), 1);
        chk("to_locked_cleared", 32'(locked8), 0);
        chk("to_period_held", 32'(period8), 2);
        send(10'd700, 1'b1);
        chk("to_timeout_one_cycle", 32'(timeout8), 0);
        chk("to_wide_counter_no_timeout", 32'(timeout), 0);
        send(10'd700, 1'b1);
        send(10'd300, 1'b1);
        send(10'd700, 1'b1);
        chk("to_rearm_needs_two_crossings", n_res8, 1);
        send(10'd300, 1'b1);
        send(10'd700, 1'b1);
        chk("to_result_after_rearm", n_res8, 2);
        chk("to_relocked", 32'(locked8), 1);
        chk("to_timeout_count", n_to8, 1);

        // Reset asserted mid-cycle of a locked full-scale stream.
        do_reset();
        for (int i = 0; i < 2600; i++) send(sine_at(i), 1'b1);
        chk("rst_locked_before", 32'(locked), 1);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_outputs_clear_async", 32'(|{result_valid, period, peak_max, peak_min, amplitude, timeout}), 0);
        chk("rst_locked_clear_async", 32'(locked), 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        n_res = 0;
        for (int i = 2600; i < 4096; i++) send(sine_at(i), 1'b1);
        chk("rst_no_stale_result", n_res, 0);
        chk("rst_period_still_zero", 32'(period), 0);
        for (int i = 4096; i < 4110; i++) send(sine_at(i), 1'b1);
        chk("rst_first_result", n_res, 1);
        chk("rst_period", 32'(period), 1024);
        chk("rst_peak_max", 32'(peak_max), 1023);
        chk("rst_peak_min", 32'(peak_min), 0);
        chk("rst_amplitude", 32'(amplitude), 511);

        chk("result_and_timeout_exclusive", both_hi, 0);

        sample_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sine_wave_analyzer.md
# sine_wave_analyzer

Receive-side counterpart of the sine wave generator. Consumes a stream of 10-bit unsigned sine samples and detects rising midscale crossings with hysteresis. For each full cycle it measures the period in samples and the peak, trough and amplitude. It sits on the sample bus fed by the generator (or an ADC), and its results drive frequency/amplitude monitoring logic.

## Interface
- `DATA_WIDTH`, 10: sample width; samples are unsigned offset binary.
- `MIDSCALE`, 512: zero-crossing reference level.
- `HYST`, 16: hysteresis half-band; must be ≥ 1 and `MIDSCALE ± HYST` must lie inside `[0, 2^DATA_WIDTH-1]`.
- `PERIOD_WIDTH`, 16: width of the period counter.
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  qualifies `data_sin`; one sample per high cycle.
- `data_sin`  in  `DATA_WIDTH`  input sample.
- `result_valid`  out  1  one-cycle pulse; all results are updated on this cycle.
- `period`  out  `PERIOD_WIDTH`  valid samples between consecutive rising crossings.
- `peak_max`  out  `DATA_WIDTH`  largest sample in the measured cycle.
- `peak_min`  out  `DATA_WIDTH`  smallest sample in the measured cycle.
- `amplitude`  out  `DATA_WIDTH`  `(peak_max - peak_min) >> 1`.
- `locked`  out  1  high after the first complete cycle is measured; cleared on timeout.
- `timeout`  out  1  one-cycle pulse when the period counter saturates.

## Operation
- All outputs are registered. While `reset` is low, every output is 0 and the FSM is in HUNT.
- Only cycles with `sample_valid = 1` advance state or counters. Invalid cycles are ignored; they never count toward `period`.
- Thresholds: "low" means `data_sin <= MIDSCALE-HYST`. "High" means `data_sin >= MIDSCALE+HYST`.
- A rising crossing is the first high sample after the FSM has seen a low sample.
- FSM states:
  - HUNT: wait for a low sample, then go to ARM1.
  - ARM1: on a high sample (first crossing), clear the counter and min/max, seed them with this sample, set count to 1, then go to MEAS_HI.
  - MEAS_HI: count samples and track min/max. On a low sample go to MEAS_LO.
  - MEAS_LO: count samples and track min/max. On a high sample (crossing):
    - Latch `period` = count, plus `peak_max`, `peak_min` and `amplitude`.
    - Pulse `result_valid` and set `locked`.
    - Reseed the counter to 1 and min/max to the crossing sample.
    - Go to MEAS_HI.
- The crossing sample belongs to the new cycle, not the one being closed.
- Min/max update: compare the incoming sample against the running value, unsigned. On the closing crossing, the latched values exclude the crossing sample.
- The amplitude subtraction never underflows because `peak_max >= peak_min` by construction.
- Counter saturation: if count reaches `2^PERIOD_WIDTH-1` in ARM1, MEAS_HI or MEAS_LO:
  - Pulse `timeout` and clear `locked`.
  - Go to HUNT.
  - Result outputs hold their last values.
- Samples inside the hysteresis band never cause transitions. Noise around midscale therefore produces no crossings.
- Outputs `period`, `peak_*` and `amplitude` hold between `result_valid` pulses.

## Timing
- Results appear and `result_valid` pulses on the clock edge after the crossing sample is presented, i.e. latency is 1 cycle.
- `result_valid` and `timeout` are never high in the same cycle.
- The first `result_valid` comes at the second rising crossing after a low sample observed in HUNT.
- Reset asserted mid-measurement: outputs clear immediately (asynchronously). After release, the FSM restarts in HUNT with no stale result.
- Back-to-back `sample_valid` is supported at full rate. The minimum measurable period is 2 samples, i.e. one low sample and one high sample alternating.

## Test plan
- **Full-scale period:** Generator with phase step 1 (1024 samples/cycle, amplitude 0..1023) for 4 cycles.
  - First `result_valid` after the second crossing.
  - Each subsequent result: `period = 1024`, `peak_max ≈ 1023`, `peak_min ≈ 0`, `amplitude ≈ 511`.
  - `locked = 1`.
- **Gapped valid:** Same stream with `sample_valid` low every other cycle → `period` still 1024. Results unchanged; cycle count is doubled.
- **Hysteresis rejection:** Square wave alternating 500/524 (inside ±16) for 200 samples → no `result_valid`, and the FSM stays in HUNT.
- **Minimum period:** Alternating samples 400/700 at full rate → `period = 2`, `peak_max = 700`, `peak_min = 400`, `amplitude = 150`, once per 2 samples.
- **Timeout:** Constant 700 after one valid low→high crossing, with `PERIOD_WIDTH = 8` → `timeout` pulses at count 255 and `locked` drops. The next crossing needs a low sample first.
- **Reset mid-cycle:** Drop `reset` for 3 cycles halfway through a 1024-sample cycle → all outputs 0 immediately. After release, the first `result_valid` only comes after two fresh crossings, with correct values.
